layer_piso: RTL and testbench

LAYER_PISO -- requirements
Module: layer_piso

---
 rtl/layer_piso_pkg.sv | 14 +
 rtl/layer_piso_word_counter.sv | 31 +++
 rtl/layer_piso.sv | 101 ++++++++++
 tb/tb_layer_piso.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/layer_piso_pkg.sv
// Shared CNN definitions: fixed-point word format and the serializer state type.
package layer_piso_pkg;

  // Bits per fixed-point word and number of fractional bits in that word.
  localparam int WORD_SIZE = 16;
  localparam int N_SIZE    = 8;

  // IDLE: empty and accepting; SEND: holding a vector and presenting words.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } piso_state_t;

endpackage

// File: rtl/layer_piso_word_counter.sv
// Word index within the vector being sent.
// Counts up from 0 and saturates at LIMIT-1; terminal flags the last word.
module word_counter
  import layer_piso_pkg::*;
#(
  parameter int LIMIT = 2,
  parameter int WIDTH = $clog2(LIMIT)
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [WIDTH-1:0] count;

  // Clear wins over enable; the counter holds at the terminal value instead of wrapping.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/layer_piso.sv
// Parallel-in serial-out converter: takes one layer vector, emits its words LSB first.
// ready_o depends combinationally on yumi_i so a new vector can be loaded while
// the last word of the current one is being consumed, with no bubble cycle.
module layer_piso
  import layer_piso_pkg::*;
#(
  parameter int LAYER_HEIGHT = 2,
  parameter int WORD_SIZE    = layer_piso_pkg::WORD_SIZE
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             valid_i,
  output logic                             ready_o,
  input  logic [LAYER_HEIGHT*WORD_SIZE-1:0] data_i,
  output logic                             valid_o,
  input  logic                             yumi_i,
  output logic [WORD_SIZE-1:0]             data_o,
  output logic                             last_o
);

  localparam int VEC_W = LAYER_HEIGHT * WORD_SIZE;

  piso_state_t      state_reg;
  piso_state_t      state_next;
  logic [VEC_W-1:0] shift_reg;
  logic             terminal;
  logic             load;
  logic             advance;
  logic             count_clear;

  word_counter #(
    .LIMIT(LAYER_HEIGHT)
  ) u_word_counter (
    .clk      (clk_i),
    .resetn   (reset_i),
    .clear    (count_clear),
    .enable   (advance),
    .terminal (terminal)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state, handshake and datapath controls.
  always_comb begin
    state_next  = state_reg;
    ready_o     = 1'b0;
    load        = 1'b0;
    advance     = 1'b0;
    count_clear = 1'b0;
    case (state_reg)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          load        = 1'b1;
          count_clear = 1'b1;
          state_next  = SEND;
        end
      end
      SEND: begin
        if (yumi_i) begin
          if (terminal) begin
            // Last word leaves now: take the next vector if offered, else go empty.
            ready_o     = 1'b1;
            count_clear = 1'b1;
            if (valid_i) begin
              load = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Vector register: load whole vector, or shift right one word so word[count] sits at the bottom.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      shift_reg <= '0;
    end else if (load) begin
      shift_reg <= data_i;
    end else if (advance) begin
      shift_reg <= {{WORD_SIZE{1'b0}}, shift_reg[VEC_W-1:WORD_SIZE]};
    end
  end

  assign valid_o = (state_reg == SEND);
  assign last_o  = valid_o & terminal;
  assign data_o  = shift_reg[WORD_SIZE-1:0];

endmodule

// File: tb/tb_layer_piso.sv
// Directed bench for layer_piso with LAYER_HEIGHT=2 and LAYER_HEIGHT=4 instances,
// checked every cycle against a queue-based model of the words still to be sent.
module tb_layer_piso;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst2, v2, y2, r2, vo2, l2;
  logic [31:0] d2;
  logic [15:0] do2;
  logic        rst4, v4, y4, r4, vo4, l4;
  logic [63:0] d4;
  logic [15:0] do4;

  layer_piso #(.LAYER_HEIGHT(2), .WORD_SIZE(16)) dut2 (
    .clk_i(clk), .reset_i(rst2), .valid_i(v2), .ready_o(r2), .data_i(d2),
    .valid_o(vo2), .yumi_i(y2), .data_o(do2), .last_o(l2)
  );

  layer_piso #(.LAYER_HEIGHT(4), .WORD_SIZE(16)) dut4 (
    .clk_i(clk), .reset_i(rst4), .valid_i(v4), .ready_o(r4), .data_i(d4),
    .valid_o(vo4), .yumi_i(y4), .data_o(do4), .last_o(l4)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: queue of words still owed downstream; zero flags "data_o must read 0 since reset".
  logic [15:0] q2[$];
  logic [15:0] q4[$];
  logic [15:0] cons2[$];
  logic [15:0] cons4[$];
  bit known2 = 0, zero2 = 0, known4 = 0, zero4 = 0;
  bit rdy2, rdy4;

  always @(posedge clk) begin
    if (!rst2) begin
      q2.delete(); known2 = 1; zero2 = 1;
    end else if (known2) begin
      rdy2 = (q2.size() == 0) || (q2.size() == 1 && y2);
      if (q2.size() != 0 && y2) void'(q2.pop_front());
      if (v2 && rdy2) begin
        for (int k = 0; k < 2; k++) q2.push_back(d2[k*16 +: 16]);
        zero2 = 0;
      end
    end
    if (!rst4) begin
      q4.delete(); known4 = 1; zero4 = 1;
    end else if (known4) begin
      rdy4 = (q4.size() == 0) || (q4.size() == 1 && y4);
      if (q4.size() != 0 && y4) void'(q4.pop_front());
      if (v4 && rdy4) begin
        for (int k = 0; k < 4; k++) q4.push_back(d4[k*16 +: 16]);
        zero4 = 0;
      end
    end
  end

  // Per-cycle comparison against the model, plus a log of consumed words.
  always @(negedge clk) begin
    if (known2) begin
      check("dut2.valid_o", 64'(vo2), 64'(q2.size() != 0));
      check("dut2.last_o", 64'(l2), 64'(q2.size() == 1));
      check("dut2.ready_o", 64'(r2), 64'((q2.size() == 0) || (q2.size() == 1 && y2)));
      if (q2.size() != 0) check("dut2.data_o", 64'(do2), 64'(q2[0]));
      else if (zero2) check("dut2.data_o_zero", 64'(do2), 64'(0));
      if (rst2 && vo2 && y2) cons2.push_back(do2);
    end
    if (known4) begin
      check("dut4.valid_o", 64'(vo4), 64'(q4.size() != 0));
      check("dut4.last_o", 64'(l4), 64'(q4.size() == 1));
      check("dut4.ready_o", 64'(r4), 64'((q4.size() == 0) || (q4.size() == 1 && y4)));
      if (q4.size() != 0) check("dut4.data_o", 64'(do4), 64'(q4[0]));
      else if (zero4) check("dut4.data_o_zero", 64'(do4), 64'(0));
      if (rst4 && vo4 && y4) cons4.push_back(do4);
    end
  end

  task automatic drive2(input logic r, input logic v, input logic [31:0] d, input logic y);
    rst2 = r; v2 = v; d2 = d; y2 = y;
    #2;
  endtask

  task automatic drive4(input logic r, input logic v, input logic [63:0] d, input logic y);
    rst4 = r; v4 = v; d4 = d; y4 = y;
    #2;
  endtask

  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp4[4];
  logic [15:0] exp_cons2[10];

  initial begin
    exp4      = '{16'h001d, 16'h0006, 16'hfffa, 16'h0035};
    exp_cons2 = '{16'h0041, 16'hfff6, 16'h0001, 16'h0002, 16'h0003,
                  16'h0004, 16'h2222, 16'h1111, 16'h1234, 16'h5678};
    rst2 = 0; v2 = 0; y2 = 0; d2 = '0;
    rst4 = 0; v4 = 0; y4 = 0; d4 = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    drive2(1, 0, 0, 0);
    drive4(1, 0, 0, 0);
    check("reset valid_o", 64'(vo2), 64'(0));
    check("reset last_o", 64'(l2), 64'(0));
    check("reset data_o", 64'(do2), 64'(0));
    check("reset ready_o", 64'(r2), 64'(1));
    check("reset4 ready_o", 64'(r4), 64'(1));
    clk_edge();

    // Single vector, yumi held high
    drive2(1, 1, 32'hfff6_0041, 1); check("p1 ready", 64'(r2), 64'(1)); clk_edge();
    drive2(1, 0, 0, 1); check("p1 w0", 64'(do2), 64'h0041); check("p1 w0 last", 64'(l2), 64'(0)); clk_edge();
    drive2(1, 0, 0, 1); check("p1 w1", 64'(do2), 64'hfff6); check("p1 w1 last", 64'(l2), 64'(1)); clk_edge();
    drive2(1, 0, 0, 0); check("p1 done", 64'(vo2), 64'(0)); clk_edge();

    // Back-to-back vectors
    drive2(1, 1, 32'h0002_0001, 0); clk_edge();
    drive2(1, 0, 0, 1); check("b2b w0", 64'(do2), 64'h0001); clk_edge();
    drive2(1, 1, 32'h0004_0003, 1); check("b2b ready", 64'(r2), 64'(1)); check("b2b w1", 64'(do2), 64'h0002); clk_edge();
    drive2(1, 0, 0, 1); check("b2b w2", 64'(do2), 64'h0003); check("b2b nogap", 64'(vo2), 64'(1)); clk_edge();
    drive2(1, 0, 0, 1); check("b2b w3", 64'(do2), 64'h0004); clk_edge();
    drive2(1, 0, 0, 0); check("b2b done", 64'(vo2), 64'(0)); clk_edge();

    // New vector offered mid-vector is ignored
    drive2(1, 1, 32'h1111_2222, 0); clk_edge();
    drive2(1, 1, 32'h3333_4444, 0); check("busy ready a", 64'(r2), 64'(0)); check("busy w0", 64'(do2), 64'h2222); clk_edge();
    drive2(1, 1, 32'h3333_4444, 1); check("busy ready b", 64'(r2), 64'(0)); clk_edge();
    drive2(1, 0, 0, 1); check("busy w1", 64'(do2), 64'h1111); check("busy last", 64'(l2), 64'(1)); clk_edge();
    drive2(1, 0, 0, 0); check("busy done", 64'(vo2), 64'(0)); clk_edge();

    // Reset mid-vector
    drive2(1, 1, 32'hbeef_cafe, 0); clk_edge();
    drive2(0, 0, 0, 1); check("rst w0", 64'(do2), 64'hcafe); clk_edge();
    drive2(1, 0, 0, 0);
    check("rst valid_o", 64'(vo2), 64'(0));
    check("rst data_o", 64'(do2), 64'(0));
    check("rst ready_o", 64'(r2), 64'(1));
    check("rst last_o", 64'(l2), 64'(0));
    clk_edge();
    repeat (2) begin
      drive2(1, 0, 0, 0); check("rst stays idle", 64'(vo2), 64'(0)); clk_edge();
    end

    // yumi in IDLE is ignored; next vector still starts at word 0
    repeat (3) begin
      drive2(1, 0, 0, 1);
      check("idle yumi valid", 64'(vo2), 64'(0));
      check("idle yumi last", 64'(l2), 64'(0));
      check("idle yumi data", 64'(do2), 64'(0));
      clk_edge();
    end
    drive2(1, 1, 32'h5678_1234, 0); clk_edge();
    drive2(1, 0, 0, 1); check("post w0", 64'(do2), 64'h1234); check("post w0 last", 64'(l2), 64'(0)); clk_edge();
    drive2(1, 0, 0, 1); check("post w1", 64'(do2), 64'h5678); check("post w1 last", 64'(l2), 64'(1)); clk_edge();
    drive2(1, 0, 0, 0); clk_edge();

    // LAYER_HEIGHT=4 with downstream stall
    drive4(1, 1, 64'h0035_fffa_0006_001d, 0); clk_edge();
    for (int i = 0; i < 3; i++) begin
      drive4(1, 0, 0, 0); check("stall hold", 64'(do4), 64'h001d); check("stall valid", 64'(vo4), 64'(1)); clk_edge();
    end
    for (int i = 0; i < 4; i++) begin
      drive4(1, 0, 0, 1);
      check("lh4 word", 64'(do4), 64'(exp4[i]));
      check("lh4 last", 64'(l4), 64'(i == 3));
      clk_edge();
    end
    drive4(1, 0, 0, 0); check("lh4 done", 64'(vo4), 64'(0)); clk_edge();

    // Consumed-word sequences
    check("cons2 count", 64'(cons2.size()), 64'(10));
    for (int i = 0; i < 10; i++) begin
      if (i < cons2.size()) check("cons2 word", 64'(cons2[i]), 64'(exp_cons2[i]));
      else check("cons2 missing", 64'(0), 64'(exp_cons2[i]));
    end
    check("cons4 count", 64'(cons4.size()), 64'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < cons4.size()) check("cons4 word", 64'(cons4[i]), 64'(exp4[i]));
      else check("cons4 missing", 64'(0), 64'(exp4[i]));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
